// File: rtl/riscv_mdu_seq.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a valid/ready op and result handshake.
module riscv_mdu_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [3:0]       op_q;
    logic             neg_q;
    logic             neg_r;

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
        return {{(WIDTH-32){x[31]}}, x};
    endfunction

    logic             in_w, in_div, in_rsv, a_signed, b_signed;
    logic             sa, sb, b_zero, ovf, is_spec;
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_val, rem_val, spec_res;

    always_comb begin
        in_w     = op[3];
        in_div   = op[2];
        in_rsv   = op[3] & ~op[2] & (op[1:0] != 2'b00);
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (in_div) begin
            a_signed = ~op[0];
            b_signed = ~op[0];
        end else if (!in_w) begin
            a_signed = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
            b_signed = (op[1:0] == 2'b01);
        end
        // W-ops work on the low word; signed variants sign-extend before abs
        if (in_w) begin
            a_ext = a_signed ? sext32(src_a[31:0]) : {{(WIDTH-32){1'b0}}, src_a[31:0]};
            b_ext = b_signed ? sext32(src_b[31:0]) : {{(WIDTH-32){1'b0}}, src_b[31:0]};
        end else begin
            a_ext = src_a;
            b_ext = src_b;
        end
        sa      = a_signed & a_ext[WIDTH-1];
        sb      = b_signed & b_ext[WIDTH-1];
        a_mag   = sa ? -a_ext : a_ext;
        b_mag   = sb ? -b_ext : b_ext;
        b_zero  = (b_ext == '0);
        min_val = in_w ? {{(WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(WIDTH-1){1'b0}}};
        ovf     = in_div & ~op[0] & (a_ext == min_val) & (b_ext == '1);
        rem_val = in_w ? sext32(src_a[31:0]) : src_a;
        is_spec = in_rsv | (in_div & (b_zero | ovf));
        spec_res = '0;
        if (in_div && b_zero)
            spec_res = op[1] ? rem_val : '1;
        else if (in_div && ovf)
            spec_res = op[1] ? '0 : a_ext;
    end

    logic [WIDTH:0]     sum, sh;
    logic [WIDTH-1:0]   diff, acc_n, lo_n, quo, rem, dval;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic               ge;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        sh   = {acc, lo[WIDTH-1]};
        ge   = (sh >= {1'b0, opnd});
        diff = sh[WIDTH-1:0] - opnd;
        if (op_q[2]) begin
            acc_n = ge ? diff : sh[WIDTH-1:0];
            lo_n  = {lo[WIDTH-2:0], ge};
        end else begin
            acc_n = sum[WIDTH:1];
            lo_n  = {sum[0], lo[WIDTH-1:1]};
        end
        prod   = {acc_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -lo_n : lo_n;
        rem    = neg_r ? -acc_n : acc_n;
        dval   = op_q[1] ? rem : quo;
        // after 32 steps the W-multiply low word sits at the top of lo
        if (op_q[2])
            fin_res = op_q[3] ? sext32(dval[31:0]) : dval;
        else if (op_q[3])
            fin_res = sext32(lo_n[WIDTH-1 -: 32]);
        else if (op_q[1:0] == 2'b00)
            fin_res = prod_s[WIDTH-1:0];
        else
            fin_res = prod_s[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            result    <= '0;
            acc       <= '0;
            lo        <= '0;
            opnd      <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_q     <= op;
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        acc      <= '0;
                        opnd     <= in_div ? b_mag : a_mag;
                        if (in_div)
                            lo <= in_w ? {a_mag[31:0], {(WIDTH-32){1'b0}}} : a_mag;
                        else
                            lo <= b_mag;
                        in_ready <= 1'b0;
                        if (is_spec) begin
                            result    <= spec_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count <= in_w ? CNT_W'(32) : CNT_W'(WIDTH);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        acc   <= acc_n;
                        lo    <= lo_n;
                        count <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            result    <= fin_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
